// File: rtl/weighted_rr_arbiter.sv
// Four-requester round-robin arbiter with a per-owner hold limit of HOLD_CYCLES cycles.
// Optional macro ARB_LOCK_EN adds a 'lock' input that lets the current owner keep the grant past the hold limit.
module weighted_rr_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req3,
    input  logic       req2,
    input  logic       req1,
    input  logic       req0,
`ifdef ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic       gnt3,
    output logic       gnt2,
    output logic       gnt1,
    output logic       gnt0,
    output logic       gnt_valid,
    output logic [1:0] gnt_id
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [3:0] HOLD = 4'(HOLD_CYCLES);

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;

    logic [3:0] reqVec;
    logic [2:0] idlePick, otherPick;
    logic       ownerReq, holdDone, lockHold;

    // Returns {found, index}; scans base+1 .. base+3, then base itself only when inclBase is set.
    function automatic logic [2:0] pickNext(input logic [3:0] r, input logic [1:0] base,
                                            input logic inclBase);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int i = 1; i <= 4; i++) begin
            idx = base + 2'(i);
            if (!res[2] && r[idx] && ((i != 4) || inclBase)) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign reqVec    = {req3, req2, req1, req0};
    assign idlePick  = pickNext(reqVec, ptr_q, 1'b1);
    assign otherPick = pickNext(reqVec, owner_q, 1'b0);
    assign ownerReq  = reqVec[owner_q];
    assign holdDone  = (cnt_q >= HOLD);
`ifdef ARB_LOCK_EN
    assign lockHold  = lock & ownerReq;
`else
    assign lockHold  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (idlePick[2]) begin
                    state_d = OWN;
                    owner_d = idlePick[1:0];
                    ptr_d   = idlePick[1:0];
                    cnt_d   = 4'd1;
                end
            end
            OWN: begin
                if (!ownerReq) begin
                    if (otherPick[2]) begin
                        owner_d = otherPick[1:0];
                        ptr_d   = otherPick[1:0];
                        cnt_d   = 4'd1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end
                end else if (lockHold) begin
                    cnt_d = holdDone ? HOLD : cnt_q + 4'd1;
                end else if (!holdDone) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (otherPick[2]) begin
                    owner_d = otherPick[1:0];
                    ptr_d   = otherPick[1:0];
                    cnt_d   = 4'd1;
                end else begin
                    // Sole requester at the limit restarts its hold without dropping the grant.
                    cnt_d = 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        gnt_valid_d = (state_d == OWN);
        gnt_d       = gnt_valid_d ? (4'b0001 << owner_d) : 4'b0000;
        gnt_id_d    = gnt_valid_d ? owner_d : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 2'd0;
            ptr_q       <= 2'd3;
            cnt_q       <= 4'd0;
            gnt_q       <= 4'b0000;
            gnt_id_q    <= 2'd0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign {gnt3, gnt2, gnt1, gnt0} = gnt_q;
    assign gnt_valid                = gnt_valid_q;
    assign gnt_id                   = gnt_id_q;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Scoreboard bench for weighted_rr_arbiter with HOLD_CYCLES=2; lock scenario runs when ARB_LOCK_EN is defined.
module tb_weighted_rr_arbiter;

    localparam int unsigned HOLD = 2;

    typedef struct {
        string    name;
        bit       rst;
        bit [3:0] req;
        bit       lock;
        bit       expValid;
        bit [1:0] expId;
    } step_t;

    typedef struct {
        string    name;
        int       due;
        bit [3:0] gnt;
        bit       valid;
        bit [1:0] id;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req3 = 1'b0, req2 = 1'b0, req1 = 1'b0, req0 = 1'b0;
    logic       lock = 1'b0;
    logic       gnt3, gnt2, gnt1, gnt0, gnt_valid;
    logic [1:0] gnt_id;

    int   total = 0;
    int   bad = 0;
    int   edgeCount = 0;
    exp_t expQ[$];
    step_t steps[$];

    weighted_rr_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .clk(clk),
        .rst(rst),
        .req3(req3),
        .req2(req2),
        .req1(req1),
        .req0(req0),
`ifdef ARB_LOCK_EN
        .lock(lock),
`endif
        .gnt3(gnt3),
        .gnt2(gnt2),
        .gnt1(gnt1),
        .gnt0(gnt0),
        .gnt_valid(gnt_valid),
        .gnt_id(gnt_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    function automatic void addStep(input string name, input bit r, input bit [3:0] rq,
                                    input bit lk, input bit v, input bit [1:0] id);
        step_t s;
        s.name = name; s.rst = r; s.req = rq; s.lock = lk; s.expValid = v; s.expId = id;
        steps.push_back(s);
    endfunction

    task automatic applyStimulus(input step_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst  = s.rst;
        {req3, req2, req1, req0} = s.req;
        lock = s.lock;
        e.name  = s.name;
        e.due   = edgeCount + 1;
        e.valid = s.expValid;
        e.id    = s.expValid ? s.expId : 2'd0;
        e.gnt   = s.expValid ? (4'b0001 << s.expId) : 4'b0000;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [3:0] gotGnt;
        gotGnt = {gnt3, gnt2, gnt1, gnt0};
        total++;
        if (gotGnt !== e.gnt) begin
            bad++;
            $display("[TB] FAIL %s.gnt cycle=%0d got=%b want=%b", e.name, e.due, gotGnt, e.gnt);
        end
        total++;
        if (gnt_valid !== e.valid) begin
            bad++;
            $display("[TB] FAIL %s.valid cycle=%0d got=%b want=%b", e.name, e.due, gnt_valid, e.valid);
        end
        total++;
        if (gnt_id !== e.id) begin
            bad++;
            $display("[TB] FAIL %s.id cycle=%0d got=%0d want=%0d", e.name, e.due, gnt_id, e.id);
        end
    endtask

    // Monitor: compares every expectation whose due edge has just passed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (expQ.size() > 0 && expQ[0].due <= edgeCount) begin
                e = expQ.pop_front();
                if (e.due < edgeCount) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL %s.late due=%0d now=%0d", e.name, e.due, edgeCount);
                end else begin
                    checkOutput(e);
                end
            end
        end
    end

    initial begin
        bit [1:0] rotIds[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        int waitCycles;

        for (int i = 0; i < 5; i++) addStep("reset_all_req", 1, 4'b1111, 0, 0, 0);
        addStep("single_req0", 0, 4'b0001, 0, 1, 0);
        addStep("single_idle", 0, 4'b0000, 0, 0, 0);
        addStep("single_idle2", 0, 4'b0000, 0, 0, 0);
        addStep("rst_again", 1, 4'b0000, 0, 0, 0);
        for (int i = 0; i < 10; i++) addStep("rotate_all", 0, 4'b1111, 0, 1, rotIds[i]);
        for (int i = 0; i < 6; i++) addStep("solo_req2", 0, 4'b0100, 0, 1, 2);
        addStep("to_owner1", 0, 4'b0010, 0, 1, 1);
        addStep("owner1_hold", 0, 4'b1011, 0, 1, 1);
        addStep("drop1_to3", 0, 4'b1001, 0, 1, 3);
        addStep("hold3", 0, 4'b1001, 0, 1, 3);
        addStep("limit_to0", 0, 4'b1001, 0, 1, 0);
        addStep("hold0", 0, 4'b1001, 0, 1, 0);
        addStep("all_drop", 0, 4'b0000, 0, 0, 0);
        addStep("ptr_wrap0", 0, 4'b0001, 0, 1, 0);
        addStep("rst_mid_own", 1, 4'b1111, 1, 0, 0);
        addStep("post_rst0", 0, 4'b1111, 0, 1, 0);
        addStep("post_rst0b", 0, 4'b1111, 0, 1, 0);
        addStep("post_rst1", 0, 4'b1111, 0, 1, 1);
`ifdef ARB_LOCK_EN
        addStep("lock_rst", 1, 4'b0000, 0, 0, 0);
        for (int i = 0; i < 5; i++) addStep("locked0", 0, 4'b0011, 1, 1, 0);
        addStep("unlock_to1", 0, 4'b0011, 0, 1, 1);
`endif

        foreach (steps[i]) applyStimulus(steps[i]);

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        #1;
        while (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            total++;
            bad++;
            $display("[TB] FAIL %s.timeout due=%0d now=%0d", e.name, e.due, edgeCount);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
